// File: rtl/rv_core_pkg.sv
// Shared core definitions: next-PC select codes, base opcodes, the canonical NOP
// and the fetch-stage state encoding.
package rv_core_pkg;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_JAL = 2'b01;
  localparam logic [1:0] PC_SEL_BR  = 2'b10;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_REQ  = 2'b01,
    FETCH_HOLD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pc_next_gen.sv
// Next-PC generator: restart address, relative jump/branch target or the
// sequential address, always word-aligned.
module pc_next_gen #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] instr_pc,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic [XLEN-1:0] pc_next
);
  import rv_core_pkg::*;

  logic [XLEN-1:0] target;

  always_comb begin
    target = instr_pc + XLEN'(4);
    if (flush) begin
      target = flush_pc;
    end else if (pc_sel == PC_SEL_JAL || pc_sel == PC_SEL_BR) begin
      target = instr_pc + imm;
    end
    // Reserved select 2'b11 falls through to the sequential address.
    pc_next = {target[XLEN-1:2], 2'b00};
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// PC and instruction-fetch stage: one outstanding word fetch, one instruction
// held for decode, redirect from the control unit and flush/restart handling.
module instr_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = rv_core_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            dec_ready,
  input  logic [1:0]      pc_sel,
  input  logic [XLEN-1:0] imm,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  output logic [31:0]     fetch_count
);
  import rv_core_pkg::*;

  fetch_state_e    state, state_d;
  logic            gap, gap_d;
  logic            kill, kill_d;
  logic [XLEN-1:0] pc, pc_d;
  logic [XLEN-1:0] req_addr, req_addr_d;
  logic [XLEN-1:0] pc_gen;
  logic [XLEN-1:0] instr_pc_d;
  logic [31:0]     instr_d;
  logic            instr_valid_d;
  logic            accept;

  assign accept    = (state == FETCH_HOLD) && dec_ready && !flush;
  // gap marks the idle cycle between a discarded response and the refetch.
  assign imem_req  = (state == FETCH_REQ) && !gap;
  assign imem_addr = req_addr;

  pc_next_gen #(.XLEN(XLEN)) u_pc_next_gen (
    .instr_pc (instr_pc),
    .pc_sel   (pc_sel),
    .imm      (imm),
    .flush    (flush),
    .flush_pc (flush_pc),
    .pc_next  (pc_gen)
  );

  assign pc_d = (flush || accept) ? pc_gen : pc;

  // NOTE: every variable gets its hold value before the case so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d       = state;
    gap_d         = gap;
    kill_d        = kill;
    req_addr_d    = req_addr;
    instr_d       = instr;
    instr_pc_d    = instr_pc;
    instr_valid_d = instr_valid;

    unique case (state)
      FETCH_IDLE: begin
        state_d    = FETCH_REQ;
        req_addr_d = pc_d;
      end
      FETCH_REQ: begin
        if (gap) begin
          gap_d      = 1'b0;
          req_addr_d = pc_d;
        end else if (imem_valid) begin
          if (kill) begin
            kill_d = 1'b0;
            gap_d  = 1'b1;
          end else if (flush) begin
            req_addr_d = pc_d;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = req_addr;
            instr_valid_d = 1'b1;
            state_d       = FETCH_HOLD;
          end
        end else if (flush) begin
          // The in-flight fetch cannot be cancelled; mark its data as stale.
          kill_d = 1'b1;
        end
      end
      FETCH_HOLD: begin
        if (flush || dec_ready) begin
          state_d       = FETCH_REQ;
          req_addr_d    = pc_d;
          instr_valid_d = 1'b0;
          instr_d       = NOP_INSTR;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase

    if (flush) begin
      instr_valid_d = 1'b0;
      instr_d       = NOP_INSTR;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH_IDLE;
      gap         <= 1'b0;
      kill        <= 1'b0;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      instr       <= NOP_INSTR;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_d;
      gap         <= gap_d;
      kill        <= kill_d;
      pc          <= pc_d;
      req_addr    <= req_addr_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      instr_valid <= instr_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (accept) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Program-counter and instruction-fetch stage. It sits directly upstream of the decode/control stage.
- Owns the PC and issues word fetches to instruction memory over a req/valid handshake.
- Presents one instruction at a time to decode, with instr_valid/dec_ready.
- Takes back the 2-bit next-PC select produced by the control unit (00 sequential, 01 jump, 10 branch taken) plus the decoded immediate, and redirects the PC.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, value driven on instr while no instruction is held (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  XLEN  fetch address; word-aligned, held stable while imem_req=1
imem_rdata  in  32  returned instruction word
imem_valid  in  1  response strobe; may assert in the same cycle as imem_req
instr  out  32  instruction to decode (opcode = instr[6:0], func3 = instr[14:12])
instr_pc  out  XLEN  address of instr
instr_valid  out  1  instr holds a live instruction
dec_ready  in  1  decode consumes instr this cycle when instr_valid=1
pc_sel  in  2  next-PC select from control unit; sampled only on an accept cycle
imm  in  XLEN  sign-extended jump/branch offset; sampled with pc_sel
flush  in  1  restart request, highest priority, any state
flush_pc  in  XLEN  restart address
fetch_count  out  32  instructions accepted by decode; wraps 2^32-1 -> 0

Behaviour:
Reset (rst_n=0, async):
- pc=RESET_PC; state IDLE; imem_req=0; imem_addr=RESET_PC.
- instr=NOP_INSTR; instr_pc=0; instr_valid=0; kill=0; fetch_count=0.

States:
- IDLE: entered only from reset. Goes to REQ on the first clock after rst_n deasserts.
- REQ:
  - imem_req=1 and imem_addr=req_addr, where req_addr is latched from pc on entry.
  - On imem_valid with kill=0: instr<=imem_rdata, instr_pc<=req_addr, instr_valid<=1, go HOLD.
  - On imem_valid with kill=1: discard rdata, kill<=0, then re-enter REQ with req_addr<=pc, with a 1-cycle imem_req gap.
- HOLD:
  - imem_req=0; instr stable.
  - Accept cycle (dec_ready=1): instr_valid<=0, instr<=NOP_INSTR, fetch_count+1, go REQ.
  - Next pc on accept:
    - pc_sel=00 or 11 (11 reserved): pc = instr_pc+4.
    - pc_sel=01 or 10: pc = instr_pc+imm.
    - Bits [1:0] of any computed pc are forced to 0. All adds are modulo 2^XLEN.
- Throughput: 2 cycles per instruction with zero-latency memory; longer memory latency adds cycles 1:1.

Flush (wins over every other event in the same cycle):
- pc<=flush_pc with [1:0] forced to 0; instr_valid<=0; instr<=NOP_INSTR.
- No fetch_count increment, even if dec_ready=1.
- In REQ without imem_valid that cycle: kill<=1; imem_req and imem_addr stay unchanged until the response arrives.
- In REQ with imem_valid that cycle: response dropped, kill stays 0, next cycle REQ at flush_pc.
- In HOLD or IDLE: next state REQ at flush_pc.
- Flush while kill=1: only pc is updated; a single response is still discarded.

Invariants:
- imem_addr never changes while imem_req=1 and no response has been seen.
- At most one fetch is outstanding at any time.
- pc_sel and imm are ignored outside accept cycles.

Decomposition:
- Shared package rv_core_pkg:
  - PC_SEL_SEQ=2'b00, PC_SEL_JAL=2'b01, PC_SEL_BR=2'b10
  - opcode constants (R, I, LOAD, STORE, JAL, BRANCH)
  - NOP_INSTR
  - fetch state enum {IDLE, REQ, HOLD}
- Combinational sub-module pc_next_gen: inputs (instr_pc, pc_sel, imm, flush, flush_pc), output the aligned next pc. The FSM, kill flag and counter stay in the top.

Test Plan:
1. Reset release, zero-latency memory returning 0x00500093 at addr 0 and dec_ready=1 with pc_sel=00 → imem_addr 0x0, 0x4, 0x8 on successive REQ cycles; instr_valid pulses every 2nd cycle; fetch_count=3 after 3 accepts.
2. Accept at instr_pc=0x10 with pc_sel=10, imm=0xFFFFFFF8 → next imem_addr=0x08. pc_sel=01, imm=0x100 at instr_pc=0x08 → 0x108. pc_sel=11 → instr_pc+4.
3. dec_ready=0 for 5 cycles in HOLD → instr and instr_pc stable, no imem_req, fetch_count unchanged; accepted on the 6th cycle.
4. imem_valid 3 cycles late, flush (flush_pc=0x200) in the 1st waiting cycle → imem_addr held until the response; response discarded, instr_valid stays 0; next request at 0x200.
5. flush in the same cycle as imem_valid, then separately in the same cycle as dec_ready=1 with pc_sel=01 → both: nothing latched or counted, next fetch at flush_pc. flush_pc=0x203 → imem_addr=0x200.
6. rst_n asserted mid-REQ (asynchronously, between edges) → outputs return to reset values immediately. After release, the first fetch is at RESET_PC; fetch_count=0xFFFFFFFF plus one accept → 0.
